// File: rtl/ternary_neuron_pkg.sv
// Shared types and constants for the ternary neuron popcount sequencer.
// Activation codes are two's complement views of +1, -1 and 0.
package ternary_neuron_pkg;

   localparam int CHUNK_W = 18;
   localparam int PC_W    = 5;

   typedef enum logic [1:0] {
      ACCEPT  = 2'd0,
      CNT_POS = 2'd1,
      CNT_NEG = 2'd2,
      RESULT  = 2'd3
   } state_e;

   localparam logic [1:0] ACT_POS  = 2'b01;
   localparam logic [1:0] ACT_NEG  = 2'b11;
   localparam logic [1:0] ACT_ZERO = 2'b00;

   typedef struct packed {
      logic [CHUNK_W-1:0] pos;
      logic [CHUNK_W-1:0] neg;
      logic               last;
   } chunk_t;

endpackage

// File: rtl/ternary_neuron_popcount_seq_core.sv
// Combinational 18-to-5 popcount shared by the positive and negative passes.
// APPROX selects the variant whose bit 4 is tied low; the sequencer uses the result as delivered.
module popcount18_shared_core
   import ternary_neuron_pkg::*;
#(
   parameter bit APPROX = 1'b0
) (
   input  logic [CHUNK_W-1:0] data_i,
   output logic [PC_W-1:0]    count_o
);

   logic [PC_W-1:0] exactCount;

   always_comb begin
      exactCount = '0;
      for (int i = 0; i < CHUNK_W; i++) begin
         exactCount = exactCount + {{(PC_W-1){1'b0}}, data_i[i]};
      end
   end

   generate
      if (APPROX) begin : gApprox
         assign count_o = {1'b0, exactCount[PC_W-2:0]};
      end else begin : gExact
         assign count_o = exactCount;
      end
   endgenerate

endmodule

// File: rtl/ternary_neuron_popcount_seq.sv
// Ternary neuron evaluator: one popcount core is time-shared over the positive and
// negative match vectors of each chunk, accumulating pos - neg before thresholding.
module ternary_neuron_popcount_seq
   import ternary_neuron_pkg::*;
#(
   parameter int MAX_CHUNKS  = 16,
   parameter int ACC_W       = 10,
   parameter bit APPROX_CORE = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CHUNK_W-1:0]      in_pos,
   input  logic [CHUNK_W-1:0]      in_neg,
   input  logic                    in_last,
   input  logic signed [ACC_W-1:0] thr_hi,
   input  logic signed [ACC_W-1:0] thr_lo,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_sum,
   output logic [1:0]              out_act,
   output logic                    err_overrun
);

   localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

   state_e                  state_q, state_d;
   chunk_t                  chunk_q, chunk_d;
   logic [CNT_W-1:0]        chunkCnt_q, chunkCnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] thrHi_q, thrHi_d;
   logic signed [ACC_W-1:0] thrLo_q, thrLo_d;
   logic                    errOverrun_q, errOverrun_d;

   logic [CHUNK_W-1:0]      coreIn;
   logic [PC_W-1:0]         coreCount;
   logic signed [ACC_W-1:0] countExt;
   logic                    acceptFire;
   logic                    cntAtLimit;
   logic                    resultFire;

   assign acceptFire = (state_q == ACCEPT) && in_valid;
   assign resultFire = (state_q == RESULT) && out_ready;
   assign cntAtLimit = (chunkCnt_q == CNT_W'(MAX_CHUNKS - 1));

   // Idle cycles feed zeros so the shared core does not toggle.
   always_comb begin
      coreIn = '0;
      if (state_q == CNT_POS) begin
         coreIn = chunk_q.pos;
      end else if (state_q == CNT_NEG) begin
         coreIn = chunk_q.neg;
      end
   end

   popcount18_shared_core #(
      .APPROX (APPROX_CORE)
   ) uCore (
      .data_i  (coreIn),
      .count_o (coreCount)
   );

   assign countExt = $signed(ACC_W'(coreCount));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCEPT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCEPT:  if (in_valid) state_d = CNT_POS;
         CNT_POS: state_d = CNT_NEG;
         CNT_NEG: state_d = (chunk_q.last || cntAtLimit) ? RESULT : ACCEPT;
         RESULT:  if (out_ready) state_d = ACCEPT;
         default: state_d = ACCEPT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chunk_q      <= '0;
         chunkCnt_q   <= '0;
         acc_q        <= '0;
         thrHi_q      <= '0;
         thrLo_q      <= '0;
         errOverrun_q <= 1'b0;
      end else begin
         chunk_q      <= chunk_d;
         chunkCnt_q   <= chunkCnt_d;
         acc_q        <= acc_d;
         thrHi_q      <= thrHi_d;
         thrLo_q      <= thrLo_d;
         errOverrun_q <= errOverrun_d;
      end
   end

   // Thresholds belong to the neuron, so only the first chunk of an evaluation loads them.
   always_comb begin
      chunk_d      = chunk_q;
      chunkCnt_d   = chunkCnt_q;
      acc_d        = acc_q;
      thrHi_d      = thrHi_q;
      thrLo_d      = thrLo_q;
      errOverrun_d = errOverrun_q;
      if (acceptFire) begin
         chunk_d.pos  = in_pos;
         chunk_d.neg  = in_neg;
         chunk_d.last = in_last;
         if (chunkCnt_q == '0) begin
            thrHi_d = thr_hi;
            thrLo_d = thr_lo;
         end
      end
      if (state_q == CNT_POS) begin
         acc_d = acc_q + countExt;
      end
      if (state_q == CNT_NEG) begin
         acc_d      = acc_q - countExt;
         chunkCnt_d = chunkCnt_q + CNT_W'(1);
         if (!chunk_q.last && cntAtLimit) begin
            errOverrun_d = 1'b1;
         end
      end
      if (resultFire) begin
         acc_d      = '0;
         chunkCnt_d = '0;
      end
   end

   always_comb begin
      in_ready  = (state_q == ACCEPT);
      out_valid = (state_q == RESULT);
      out_sum   = acc_q;
      out_act   = ACT_ZERO;
      if (state_q == RESULT) begin
         if (acc_q >= thrHi_q) begin
            out_act = ACT_POS;
         end else if (acc_q <= thrLo_q) begin
            out_act = ACT_NEG;
         end
      end
   end

   assign err_overrun = errOverrun_q;

endmodule

// File: tb/tb_ternary_neuron_popcount_seq.sv
// Scoreboard bench: directed chunks push hand-computed results, a negedge monitor
// pops and compares them on every result handshake.
module tb_ternary_neuron_popcount_seq;

   localparam int MAX_CHUNKS = 16;
   localparam int ACC_W      = 10;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [17:0]             in_pos;
   logic [17:0]             in_neg;
   logic                    in_last;
   logic signed [ACC_W-1:0] thr_hi;
   logic signed [ACC_W-1:0] thr_lo;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_sum;
   logic [1:0]              out_act;
   logic                    err_overrun;

   ternary_neuron_popcount_seq #(
      .MAX_CHUNKS  (MAX_CHUNKS),
      .ACC_W       (ACC_W),
      .APPROX_CORE (1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pos      (in_pos),
      .in_neg      (in_neg),
      .in_last     (in_last),
      .thr_hi      (thr_hi),
      .thr_lo      (thr_lo),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_act     (out_act),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      string tag;
      int    sum;
      int    act;
      int    err;
   } expect_t;

   expect_t expQ[$];
   expect_t monEntry;
   int      checks = 0;
   int      fails  = 0;

   // Chunk counts: (5,2), (0,9), (4,4) -> -6
   localparam logic [17:0] POS3 [3] = '{18'h0001F, 18'h00000, 18'h0000F};
   localparam logic [17:0] NEG3 [3] = '{18'h00003, 18'h001FF, 18'h000F0};
   // Sum 7 against (thr_hi, thr_lo) -> activation code
   localparam int THR_HI [4] = '{7, 8, 8, 7};
   localparam int THR_LO [4] = '{-10, 7, 6, 7};
   localparam int THR_ACT[4] = '{1, 3, 0, 1};

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic pushExpect(input string tag, input int sum, input int act, input int err);
      expect_t e;
      e.tag = tag;
      e.sum = sum;
      e.act = act;
      e.err = err;
      expQ.push_back(e);
   endtask

   task automatic driveChunk(input logic [17:0] pos, input logic [17:0] neg, input logic last,
                             input int hi, input int lo);
      in_pos   = pos;
      in_neg   = neg;
      in_last  = last;
      thr_hi   = ACC_W'(hi);
      thr_lo   = ACC_W'(lo);
      in_valid = 1'b1;
   endtask

   // Returns 1 ns after the accepting edge, i.e. with the DUT in CNT_POS.
   task automatic applyStimulus(input logic [17:0] pos, input logic [17:0] neg, input logic last,
                                input int hi, input int lo);
      int waitCycles;
      waitCycles = 0;
      driveChunk(pos, neg, last, hi, lo);
      while (!in_ready && waitCycles < 50) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      if (!in_ready) begin
         checks++;
         fails++;
         $display("[TB] FAIL accept_timeout: in_ready still %0b after %0d cycles, required 1", in_ready, waitCycles);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_result: got sum %0d act %0d, required no result", $signed(out_sum), out_act);
         end else begin
            monEntry = expQ.pop_front();
            checkOutput({monEntry.tag, "_sum"}, int'($signed(out_sum)), monEntry.sum);
            checkOutput({monEntry.tag, "_act"}, int'(out_act), monEntry.act);
            checkOutput({monEntry.tag, "_err"}, int'(err_overrun), monEntry.err);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_pos    = '0;
      in_neg    = '0;
      in_last   = 1'b0;
      thr_hi    = '0;
      thr_lo    = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_in_ready", int'(in_ready), 1);
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_out_sum", int'($signed(out_sum)), 0);
      checkOutput("reset_out_act", int'(out_act), 0);
      checkOutput("reset_err", int'(err_overrun), 0);

      $display("[TB] single full chunk");
      pushExpect("single", 18, 1, 0);
      applyStimulus(18'h3FFFF, 18'h00000, 1'b1, 10, -10);
      checkOutput("single_cnt_pos_valid", int'(out_valid), 0);
      checkOutput("single_cnt_pos_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      checkOutput("single_cnt_neg_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      checkOutput("single_latency_valid", int'(out_valid), 1);
      @(posedge clk);
      #1;
      checkOutput("single_back_ready", int'(in_ready), 1);
      checkOutput("single_back_valid", int'(out_valid), 0);

      $display("[TB] three chunks");
      pushExpect("three", -6, 3, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(POS3[i], NEG3[i], (i == 2), 3, -3);
         checkOutput("three_ready_cnt_pos", int'(in_ready), 0);
         @(posedge clk);
         #1;
         checkOutput("three_ready_cnt_neg", int'(in_ready), 0);
         @(posedge clk);
         #1;
         if (i < 2) begin
            checkOutput("three_ready_accept", int'(in_ready), 1);
         end else begin
            checkOutput("three_result_valid", int'(out_valid), 1);
         end
      end
      @(posedge clk);
      #1;

      $display("[TB] threshold boundaries");
      for (int t = 0; t < 4; t++) begin
         pushExpect($sformatf("thr%0d", t), 7, THR_ACT[t], 0);
         applyStimulus(18'h0007F, 18'h00000, 1'b1, THR_HI[t], THR_LO[t]);
         repeat (3) @(posedge clk);
         #1;
      end

      $display("[TB] backpressure");
      out_ready = 1'b0;
      pushExpect("bp_first", 5, 1, 0);
      applyStimulus(18'h0003F, 18'h00001, 1'b1, 3, -3);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("bp_valid", int'(out_valid), 1);
      driveChunk(18'h00003, 18'h00000, 1'b1, 10, -10);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_hold_valid", int'(out_valid), 1);
         checkOutput("bp_hold_sum", int'($signed(out_sum)), 5);
         checkOutput("bp_hold_act", int'(out_act), 1);
         checkOutput("bp_hold_ready", int'(in_ready), 0);
      end
      pushExpect("bp_second", 2, 0, 0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_release_ready", int'(in_ready), 1);
      checkOutput("bp_release_valid", int'(out_valid), 0);
      checkOutput("bp_acc_restart", int'($signed(out_sum)), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("bp_chunk_taken", int'(in_ready), 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("bp_second_valid", int'(out_valid), 1);
      @(posedge clk);
      #1;

      $display("[TB] overrun");
      pushExpect("overrun", 16, 0, 1);
      for (int k = 0; k < MAX_CHUNKS; k++) begin
         applyStimulus(18'h00001, 18'h00000, 1'b0, 100, -100);
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput("overrun_valid", int'(out_valid), 1);
      checkOutput("overrun_flag", int'(err_overrun), 1);
      @(posedge clk);
      #1;
      pushExpect("after_overrun", 3, 0, 1);
      applyStimulus(18'h00007, 18'h00000, 1'b1, 10, -10);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("overrun_sticky", int'(err_overrun), 1);

      $display("[TB] reset mid-evaluation");
      applyStimulus(18'h00003, 18'h00000, 1'b0, 10, -10);
      applyStimulus(18'h0000F, 18'h00000, 1'b0, 10, -10);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midrst_in_ready", int'(in_ready), 1);
      checkOutput("midrst_out_valid", int'(out_valid), 0);
      checkOutput("midrst_acc", int'($signed(out_sum)), 0);
      checkOutput("midrst_err", int'(err_overrun), 0);
      pushExpect("post_reset", 2, 0, 0);
      applyStimulus(18'h00007, 18'h00001, 1'b1, 10, -10);
      repeat (3) @(posedge clk);
      #1;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", expQ.size(), 0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/ternary_neuron_popcount_seq.md
Name: ternary_neuron_popcount_seq

Overview:
- Sequences one shared 18-input popcount core to evaluate one ternary neuron whose fan-in spans up to MAX_CHUNKS 18-bit chunks.
- Each chunk carries a positive-match vector and a negative-match vector. Both are counted on the same core in consecutive cycles.
- The block accumulates pos − neg and applies two thresholds to produce a ternary activation.
- It sits between the input-activation/weight streamer and the neuron output buffer of the printed-NN layer.

Parameters:
- MAX_CHUNKS, 16, maximum chunks per neuron evaluation.
- ACC_W, 10, signed accumulator width; must satisfy 2^(ACC_W-1) > 18*MAX_CHUNKS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  chunk available
- in_ready  out  1  block accepts a chunk
- in_pos  in  18  bits whose input matches a +1 weight
- in_neg  in  18  bits whose input matches a −1 weight
- in_last  in  1  final chunk of this neuron
- thr_hi  in  ACC_W  signed upper threshold; sampled on the first chunk accept
- thr_lo  in  ACC_W  signed lower threshold; sampled on the first chunk accept
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_sum  out  ACC_W  signed accumulated pos − neg
- out_act  out  2  activation: 2'b01 = +1, 2'b11 = −1, 2'b00 = 0
- err_overrun  out  1  sticky flag: MAX_CHUNKS reached without in_last

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_act=0, err_overrun=0. Accumulator and chunk counter are 0. State is ACCEPT.
- A reset mid-evaluation discards the partial sum. No output is produced for the discarded neuron.
- ACCEPT:
  - in_ready=1.
  - On in_valid&&in_ready: register in_pos, in_neg and in_last.
  - If the chunk counter is 0, also register thr_hi and thr_lo.
  - Go to CNT_POS.
- CNT_POS:
  - in_ready=0.
  - Popcount core input is the pos register; acc <= acc + zero-extended count (5-bit, 0..18).
  - Go to CNT_NEG.
- CNT_NEG:
  - in_ready=0.
  - Core input is the neg register; acc <= acc − count; chunk counter increments.
  - If last_reg=1 or the counter reaches MAX_CHUNKS-1 before increment: go to RESULT.
  - In the forced case (MAX_CHUNKS reached without last_reg), also set err_overrun.
  - Otherwise return to ACCEPT.
- RESULT:
  - out_valid=1 and in_ready=0.
  - out_sum = acc.
  - out_act = +1 if acc >= thr_hi; else −1 if acc <= thr_lo; else 0. If both thresholds match, +1 has priority.
  - Outputs are held stable while out_ready=0.
  - On out_ready: clear acc and the counter, drop out_valid next cycle, go to ACCEPT.
- Throughput and latency:
  - 3 cycles per chunk.
  - out_valid asserts 2 cycles after the handshake of the last chunk.
  - A new chunk can be accepted in the cycle after the result handshake.
- Core idle: when not counting, core input is driven to 0 to minimise switching.
- Core output: its bit 4 may be constant 0 for approximate cores. The block uses the 5-bit value as delivered, with no correction.
- Arithmetic: all arithmetic is signed, two's complement, ACC_W bits. Overflow cannot occur under the ACC_W constraint.
- err_overrun: clears only on rst.
- Ignored inputs: in_valid is ignored outside ACCEPT. Held data is not consumed until the block returns to ACCEPT.

Decomposition:
- Package ternary_neuron_pkg holds:
  - state enum {ACCEPT, CNT_POS, CNT_NEG, RESULT};
  - constants CHUNK_W=18 and PC_W=5;
  - activation encodings ACT_POS, ACT_NEG, ACT_ZERO.
- Sub-module popcount18_shared_core: a combinational 18-to-5 popcount wrapper around the team's selected popcount18 variant.
  - Exact or approximate is chosen at build time.
  - This lets the verifier swap in an exact core for reference checks.

Test Plan:
- Single chunk, pos=18'h3FFFF, neg=0, thr_hi=10, thr_lo=−10, in_last=1 -> out_sum=18, out_act=+1, out_valid 2 cycles after accept (exact core).
- Three chunks with pos/neg counts (5,2), (0,9), (4,4), thr_hi=3, thr_lo=−3 -> out_sum=−6, out_act=−1. in_ready pattern is 1,0,0 per chunk.
- Sum exactly at a threshold: pos=7, neg=0, thr_hi=7 -> out_act=+1. Same sum with thr_hi=8, thr_lo=7 -> out_act=−1. With thr_hi=8, thr_lo=6 -> out_act=0.
- Backpressure: hold out_ready=0 for 5 cycles in RESULT -> out_sum and out_act stable, in_ready=0, in_valid chunk not consumed. Release -> next chunk accepted 1 cycle after the handshake and the accumulator restarts from 0.
- 16 chunks, none with in_last, each pos=1 -> result after 16th chunk with out_sum=16 and err_overrun=1. err_overrun stays 1 across the next neuron until rst.
- Assert rst during CNT_NEG of chunk 2 -> next cycle in_ready=1, out_valid=0, acc=0. A new single chunk (pos=3, neg=1) yields out_sum=2.
